sample_frame_ctrl: RTL and testbench

Sequences one frame load from the 4-word-per-cycle sample source into the frame buffer. It raises the source start, captures each 4-word group as a buffer write, and counts groups. It checks completion, overflow and stalls, then hands the filled frame to the compute stage with a ready/ack handshake. It sits between the sample source and the 32-point processing datapath.

---
 rtl/sfc_pkg.sv | 23 ++
 rtl/sfc_watchdog.sv | 34 +++
 rtl/sample_frame_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sample_frame_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfc_pkg.sv
// sfc_pkg: shared definitions for the sample frame controller.
//   - sfc_state_e : controller state encoding (3-bit)
//   - ERR_*       : err_code values reported on the err_code port
//   - SFC_*       : default frame geometry
package sfc_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_CAPTURE = 3'd2,
        S_RELEASE = 3'd3,
        S_READY   = 3'd4
    } sfc_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_SHORT   = 2'd3;

    localparam int unsigned SFC_WORDSIZE   = 16;
    localparam int unsigned SFC_NUMSAMPLES = 32;

endpackage

// File: rtl/sfc_watchdog.sv
// sfc_watchdog: counts consecutive idle cycles while a frame is loading.
// Ports:
//   clk       in  clock
//   rst_n     in  synchronous active-low reset
//   clr_i     in  zero the count (source delivered data, or not loading)
//   en_i      in  this cycle is an idle loading cycle
//   expired_o out high during the TIMEOUT-th consecutive idle cycle
module sfc_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Flags the cycle whose edge would bring the count to TIMEOUT, so the
    // controller leaves on exactly the TIMEOUT-th idle cycle.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sample_frame_ctrl.sv
// sample_frame_ctrl: loads one frame from a 4-word-per-cycle sample source
// into the frame buffer, then hands it to the compute stage.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start, abort                load request / cancel
//   src_s                       start level to the sample source
//   src_valid, src_done         source group strobe / end-of-frame level
//   src_data0..3                group words, data0 = lowest sample index
//   buf_we, buf_gaddr, buf_wdata  frame buffer write port (1-cycle latency)
//   frame_ready, frame_ack      hand-off handshake to the consumer
//   busy                        high in every state except IDLE
//   error, err_code             sticky fault flag and cause
module sample_frame_ctrl
    import sfc_pkg::*;
#(
    parameter int unsigned WORDSIZE   = SFC_WORDSIZE,
    parameter int unsigned NUMSAMPLES = SFC_NUMSAMPLES,
    parameter int unsigned NUMGROUPS  = NUMSAMPLES / 4,
    parameter int unsigned GADDRW     = 3,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    src_s,
    input  logic                    src_valid,
    input  logic                    src_done,
    input  logic [WORDSIZE-1:0]     src_data0,
    input  logic [WORDSIZE-1:0]     src_data1,
    input  logic [WORDSIZE-1:0]     src_data2,
    input  logic [WORDSIZE-1:0]     src_data3,
    output logic                    buf_we,
    output logic [GADDRW-1:0]       buf_gaddr,
    output logic [4*WORDSIZE-1:0]   buf_wdata,
    output logic                    frame_ready,
    input  logic                    frame_ack,
    output logic                    busy,
    output logic                    error,
    output logic [1:0]              err_code
);

    localparam int unsigned GCW = GADDRW + 1;
    localparam logic [GCW-1:0] GCNT_FULL = GCW'(NUMGROUPS);

    sfc_state_e            state_q;
    logic                  src_s_q;
    logic                  buf_we_q;
    logic [GADDRW-1:0]     buf_gaddr_q;
    logic [4*WORDSIZE-1:0] buf_wdata_q;
    logic                  frame_ready_q;
    logic                  busy_q;
    logic                  error_q;
    logic [1:0]            err_code_q;
    logic                  aborted_q;
    logic [GCW-1:0]        gcnt_q;

    logic                  loading;
    logic [GCW-1:0]        gcnt_d;
    logic                  wd_expired;

    assign loading = (state_q == S_REQ) || (state_q == S_CAPTURE);

    // Count after this cycle's valid; src_done is judged against it so a
    // final group arriving alongside done still completes the frame.
    always_comb begin
        gcnt_d = gcnt_q;
        if (src_valid && (gcnt_q != GCNT_FULL)) begin
            gcnt_d = gcnt_q + GCW'(1);
        end
    end

    sfc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!loading || src_valid),
        .en_i      (loading && !src_valid),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            src_s_q       <= 1'b0;
            buf_we_q      <= 1'b0;
            buf_gaddr_q   <= '0;
            buf_wdata_q   <= '0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            aborted_q     <= 1'b0;
            gcnt_q        <= '0;
        end else begin
            buf_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_REQ;
                        src_s_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                        aborted_q  <= 1'b0;
                        gcnt_q     <= '0;
                    end
                end

                // REQ differs from CAPTURE only in that the first valid
                // group moves the state on; both capture identically.
                S_REQ, S_CAPTURE: begin
                    if (abort) begin
                        state_q   <= S_RELEASE;
                        src_s_q   <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (src_valid && (gcnt_q == GCNT_FULL)) begin
                        state_q    <= S_RELEASE;
                        src_s_q    <= 1'b0;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_OVF;
                    end else begin
                        if (src_valid) begin
                            state_q     <= S_CAPTURE;
                            buf_we_q    <= 1'b1;
                            buf_gaddr_q <= gcnt_q[GADDRW-1:0];
                            buf_wdata_q <= {src_data3, src_data2, src_data1, src_data0};
                            gcnt_q      <= gcnt_d;
                        end
                        if (src_done) begin
                            state_q <= S_RELEASE;
                            src_s_q <= 1'b0;
                            if (gcnt_d != GCNT_FULL) begin
                                error_q    <= 1'b1;
                                err_code_q <= ERR_SHORT;
                            end
                        end else if (wd_expired) begin
                            state_q    <= S_RELEASE;
                            src_s_q    <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_TIMEOUT;
                        end
                    end
                end

                S_RELEASE: begin
                    if (!src_done) begin
                        if (!error_q && !aborted_q) begin
                            state_q       <= S_READY;
                            frame_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                S_READY: begin
                    if (frame_ack) begin
                        state_q       <= S_IDLE;
                        frame_ready_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign src_s       = src_s_q;
    assign buf_we      = buf_we_q;
    assign buf_gaddr   = buf_gaddr_q;
    assign buf_wdata   = buf_wdata_q;
    assign frame_ready = frame_ready_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// tb_sample_frame_ctrl: directed self-checking bench for sample_frame_ctrl.
module tb_sample_frame_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        src_s;
    logic        src_valid;
    logic        src_done;
    logic [15:0] src_data0;
    logic [15:0] src_data1;
    logic [15:0] src_data2;
    logic [15:0] src_data3;
    logic        buf_we;
    logic [2:0]  buf_gaddr;
    logic [63:0] buf_wdata;
    logic        frame_ready;
    logic        frame_ack;
    logic        busy;
    logic        error;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;
    int wr_total = 0;
    int fr_total = 0;
    int wb;
    int fb;

    sample_frame_ctrl #(
        .WORDSIZE   (16),
        .NUMSAMPLES (32),
        .GADDRW     (3),
        .TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .src_s       (src_s),
        .src_valid   (src_valid),
        .src_done    (src_done),
        .src_data0   (src_data0),
        .src_data1   (src_data1),
        .src_data2   (src_data2),
        .src_data3   (src_data3),
        .buf_we      (buf_we),
        .buf_gaddr   (buf_gaddr),
        .buf_wdata   (buf_wdata),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack),
        .busy        (busy),
        .error       (error),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running totals of write strobes and frame_ready cycles.
    always @(negedge clk) begin
        if (buf_we) wr_total = wr_total + 1;
        if (frame_ready) fr_total = fr_total + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, observed no end, required end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_errors = n_errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Group g carries samples 4g..4g+3, word k = sample index.
    function automatic logic [63:0] grp(input int g);
        return {16'(4*g+3), 16'(4*g+2), 16'(4*g+1), 16'(4*g)};
    endfunction

    task automatic drive_group(input int g);
        src_valid = 1'b1;
        src_data0 = 16'(4*g);
        src_data1 = 16'(4*g+1);
        src_data2 = 16'(4*g+2);
        src_data3 = 16'(4*g+3);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_groups(input string tag, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) tick();
            drive_group(i);
            tick();
            src_valid = 1'b0;
            check({tag, "_we"}, 64'(buf_we), 64'd1);
            check({tag, "_gaddr"}, 64'(buf_gaddr), 64'(i));
            check({tag, "_wdata"}, buf_wdata, grp(i));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, 64'({src_s, buf_we, frame_ready, busy, error, err_code, buf_gaddr}), 64'd0);
        check({tag, "_wdata"}, buf_wdata, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_done = 1'b0;
        frame_ack = 1'b0;
        src_data0 = '0; src_data1 = '0; src_data2 = '0; src_data3 = '0;

        // Reset
        tick(); tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: nominal frame
        wb = wr_total;
        start_frame();
        check("t1_src_s", 64'(src_s), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        drive_group(0);
        tick();
        src_valid = 1'b0;
        check("t1_g0_wdata", buf_wdata, 64'h0003_0002_0001_0000);
        check("t1_g0_gaddr", 64'(buf_gaddr), 64'd0);
        for (int g = 1; g < 8; g++) begin
            drive_group(g);
            tick();
            src_valid = 1'b0;
            check("t1_gaddr", 64'(buf_gaddr), 64'(g));
            check("t1_wdata", buf_wdata, grp(g));
        end
        src_done = 1'b1;
        tick();
        check("t1_no_extra_we", 64'(buf_we), 64'd0);
        check("t1_src_s_drop", 64'(src_s), 64'd0);
        check("t1_ready_early", 64'(frame_ready), 64'd0);
        src_done = 1'b0;
        tick();
        check("t1_ready", 64'(frame_ready), 64'd1);
        check("t1_error", 64'({error, err_code}), 64'd0);
        check("t1_writes", 64'(wr_total - wb), 64'd8);
        tick(); tick();
        check("t1_ready_hold", 64'(frame_ready), 64'd1);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("t1_ack_ready", 64'(frame_ready), 64'd0);
        check("t1_ack_busy", 64'(busy), 64'd0);

        // 2: gapped source
        wb = wr_total;
        start_frame();
        load_groups("t2", 8, 5);
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        tick();
        check("t2_ready", 64'(frame_ready), 64'd1);
        check("t2_error", 64'({error, err_code}), 64'd0);
        check("t2_writes", 64'(wr_total - wb), 64'd8);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("t2_busy", 64'(busy), 64'd0);

        // 3: stall -> timeout on the 64th idle cycle
        fb = fr_total;
        start_frame();
        load_groups("t3", 3, 0);
        repeat (63) tick();
        check("t3_src_s_63", 64'(src_s), 64'd1);
        check("t3_error_63", 64'(error), 64'd0);
        tick();
        check("t3_src_s_64", 64'(src_s), 64'd0);
        check("t3_error", 64'(error), 64'd1);
        check("t3_err_code", 64'(err_code), 64'd1);
        tick();
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_error_sticky", 64'(error), 64'd1);
        check("t3_no_ready", 64'(fr_total - fb), 64'd0);

        // 4a: overflow on a 9th group
        wb = wr_total;
        fb = fr_total;
        start_frame();
        check("t4a_err_cleared", 64'({error, err_code}), 64'd0);
        load_groups("t4a", 8, 0);
        drive_group(8);
        tick();
        src_valid = 1'b0;
        check("t4a_no_9th_we", 64'(buf_we), 64'd0);
        check("t4a_error", 64'(error), 64'd1);
        check("t4a_err_code", 64'(err_code), 64'd2);
        check("t4a_src_s", 64'(src_s), 64'd0);
        tick();
        check("t4a_busy", 64'(busy), 64'd0);
        check("t4a_writes", 64'(wr_total - wb), 64'd8);
        check("t4a_no_ready", 64'(fr_total - fb), 64'd0);

        // 4b: short frame after 6 groups
        wb = wr_total;
        start_frame();
        load_groups("t4b", 6, 0);
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        check("t4b_error", 64'(error), 64'd1);
        check("t4b_err_code", 64'(err_code), 64'd3);
        check("t4b_src_s", 64'(src_s), 64'd0);
        tick();
        check("t4b_busy", 64'(busy), 64'd0);
        check("t4b_writes", 64'(wr_total - wb), 64'd6);

        // 5a: abort after group 4
        wb = wr_total;
        fb = fr_total;
        start_frame();
        load_groups("t5a", 4, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5a_src_s", 64'(src_s), 64'd0);
        check("t5a_error", 64'({error, err_code}), 64'd0);
        tick();
        check("t5a_busy", 64'(busy), 64'd0);
        check("t5a_no_ready", 64'(fr_total - fb), 64'd0);
        check("t5a_writes", 64'(wr_total - wb), 64'd4);

        // 5b: reset mid-capture, with a valid group offered at the reset edge
        start_frame();
        load_groups("t5b_pre", 3, 0);
        drive_group(3);
        rst_n = 1'b0;
        tick();
        src_valid = 1'b0;
        check_outputs_zero("t5b_reset");
        rst_n = 1'b1;
        tick();
        wb = wr_total;
        start_frame();
        load_groups("t5b", 8, 0);
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        tick();
        check("t5b_ready", 64'(frame_ready), 64'd1);
        check("t5b_error", 64'({error, err_code}), 64'd0);
        check("t5b_writes", 64'(wr_total - wb), 64'd8);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;

        // 6: 8th group coincident with src_done; start ignored while READY
        start_frame();
        load_groups("t6", 7, 0);
        drive_group(7);
        src_done = 1'b1;
        tick();
        src_valid = 1'b0;
        src_done = 1'b0;
        check("t6_we", 64'(buf_we), 64'd1);
        check("t6_gaddr", 64'(buf_gaddr), 64'd7);
        check("t6_wdata", buf_wdata, grp(7));
        check("t6_src_s", 64'(src_s), 64'd0);
        check("t6_error", 64'({error, err_code}), 64'd0);
        tick();
        check("t6_ready", 64'(frame_ready), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_start_ignored_ready", 64'(frame_ready), 64'd1);
        check("t6_start_ignored_src_s", 64'(src_s), 64'd0);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("t6_ack_ready", 64'(frame_ready), 64'd0);
        check("t6_ack_busy", 64'(busy), 64'd0);
        start_frame();
        check("t6_restart_src_s", 64'(src_s), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("t6_final_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
